// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: KLP32 multi-cycle control sequencer.
// Steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB.
// It runs the imem/dmem request/acknowledge handshakes. It converts the
// decoder's level outputs into single-cycle write strobes and counts retired
// instructions.
// Optional feature: define MSEQ_TRAP_EN so that an illegal opcode enters a
// sticky TRAP state. Without it, an illegal opcode retires as a NOP.
`timescale 1ns/1ps
module multicycle_sequencer #(
    parameter int unsigned n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    output logic         imem_req,
    input  logic         imem_ack,
    input  logic [n-1:0] imem_rdata,
    output logic [n-1:0] instr,
    input  logic         RegWEn_in,
    input  logic         MemRw_in,
    input  logic         PCSel_in,
    output logic         dmem_req,
    output logic         dmem_we,
    input  logic         dmem_ack,
    output logic         reg_we,
    output logic         pc_we,
    output logic         pc_sel,
    output logic         retire,
    output logic [31:0]  instret,
    output logic         busy,
    output logic         trap
);
    localparam int unsigned OpW = 7;

    localparam logic [OpW-1:0] opAluR  = 7'b0110011;
    localparam logic [OpW-1:0] opAluI  = 7'b0010011;
    localparam logic [OpW-1:0] opStore = 7'b0100011;
    localparam logic [OpW-1:0] opBr    = 7'b1100011;
    localparam logic [OpW-1:0] opLoad  = 7'b0000011;
    localparam logic [OpW-1:0] opJal   = 7'b1101111;
    localparam logic [OpW-1:0] opJalr  = 7'b1100111;
    localparam logic [OpW-1:0] opLui   = 7'b0110111;
    localparam logic [OpW-1:0] opAuipc = 7'b0010111;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } stateT;

    stateT          state;
    logic [OpW-1:0] opcode;
    logic           isLegal;
    logic           isMemOp;
    logic           isJump;

    // Opcode classification from the registered IR
    always_comb begin
        opcode  = instr[OpW-1:0];
        isLegal = opcode inside {opAluR, opAluI, opStore, opBr, opLoad,
                                 opJal, opJalr, opLui, opAuipc};
        isMemOp = (opcode == opLoad) || (opcode == opStore);
        isJump  = (opcode == opJal) || (opcode == opJalr);
    end

    // State, IR and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            instr   <= '0;
            instret <= '0;
        end else begin
            if (retire) begin
                instret <= instret + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        state <= DECODE;
                    end
                end
                DECODE: begin
`ifdef MSEQ_TRAP_EN
                    state <= isLegal ? EXEC : TRAP;
`else
                    state <= EXEC;
`endif
                end
                EXEC: begin
                    state <= isMemOp ? MEM : WB;
                end
                MEM: begin
                    if (dmem_ack) begin
                        if (MemRw_in) begin
                            state <= run ? FETCH : IDLE;
                        end else begin
                            state <= WB;
                        end
                    end
                end
                WB: begin
                    state <= run ? FETCH : IDLE;
                end
                TRAP: begin
                    state <= TRAP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake requests and single-cycle strobes decoded from state and IR
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        retire   = 1'b0;
        trap     = 1'b0;
        busy     = (state != IDLE);
        case (state)
            FETCH: begin
                imem_req = 1'b1;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = MemRw_in;
                if (dmem_ack && MemRw_in) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            WB: begin
                // An illegal opcode that reaches WB retires as a NOP
                reg_we = RegWEn_in && isLegal;
                pc_we  = 1'b1;
                pc_sel = isLegal && (PCSel_in || isJump);
                retire = 1'b1;
            end
`ifdef MSEQ_TRAP_EN
            TRAP: begin
                trap = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

endmodule
